// File: rtl/exe_mdu_pkg.sv
// Shared op encodings (RISC-V funct3) and operand-signedness helpers for the multiply/divide unit.
package exe_mdu_pkg;

    localparam int unsigned MDU_OP_WIDTH = 3;

    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MUL    = 3'b000;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULH   = 3'b001;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHSU = 3'b010;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_MULHU  = 3'b011;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIV    = 3'b100;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_DIVU   = 3'b101;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REM    = 3'b110;
    localparam logic [MDU_OP_WIDTH-1:0] MDU_OP_REMU   = 3'b111;

    function automatic logic mdu_op_is_div(input logic [MDU_OP_WIDTH-1:0] op);
        return op[2];
    endfunction

    function automatic logic mdu_op_a_signed(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
               (op == MDU_OP_DIV)  || (op == MDU_OP_REM);
    endfunction

    function automatic logic mdu_op_b_signed(input logic [MDU_OP_WIDTH-1:0] op);
        return (op == MDU_OP_MULH) || (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    endfunction

endpackage

// File: rtl/exe_mdu_div.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per enabled step.
module exe_mdu_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // Dividend bits shift out of quot_q into the partial remainder as quotient bits shift in.
    assign shifted = {rem_q, quot_q[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (load) begin
            quot_q <= dividend;
            rem_q  <= '0;
            dvs_q  <= divisor;
        end else if (step) begin
            quot_q <= {quot_q[XLEN-2:0], ~diff[XLEN]};
            rem_q  <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
        end
    end

    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/exe_mdu.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier, restoring divider,
// early-out for divide-by-zero and signed overflow, annul and registered outputs.
module exe_mdu
    import exe_mdu_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned MUL_BITS = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    I_valid,
    input  logic [MDU_OP_WIDTH-1:0] I_op,
    input  logic [XLEN-1:0]         I_srca,
    input  logic [XLEN-1:0]         I_srcb,
    input  logic                    I_annul,
    output logic                    O_ready,
    output logic                    O_valid,
    output logic [XLEN-1:0]         O_result
);

    localparam int unsigned      CNT_W     = $clog2(XLEN) + 1;
    localparam int unsigned      MUL_STEPS = XLEN / MUL_BITS;
    localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_STEPS - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StDiv  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    valid_q;
    logic [XLEN-1:0]         result_q;

    logic [MDU_OP_WIDTH-1:0] op_q;
    logic                    neg_q;
    logic                    sign_a_q;
    logic                    early_q;
    logic [XLEN-1:0]         early_res_q;
    logic [XLEN-1:0]         mcand_q;
    logic [2*XLEN-1:0]       prod_q;

    logic                    accept;
    logic                    sign_a, sign_b;
    logic [XLEN-1:0]         mag_a, mag_b;
    logic                    div_zero, div_ovf, early;
    logic [XLEN-1:0]         early_res;
    logic                    div_step;
    logic [XLEN-1:0]         div_quot, div_rem;
    logic [XLEN+MUL_BITS-1:0] partial, mul_sum;
    logic [2*XLEN-1:0]       prod_fix;
    logic [XLEN-1:0]         quot_fix, rem_fix, fix_result;

    assign accept   = I_valid & (state_q == StIdle) & ~I_annul;
    assign sign_a   = mdu_op_a_signed(I_op) & I_srca[XLEN-1];
    assign sign_b   = mdu_op_b_signed(I_op) & I_srcb[XLEN-1];
    assign mag_a    = sign_a ? -I_srca : I_srca;
    assign mag_b    = sign_b ? -I_srcb : I_srcb;
    assign div_zero = (I_srcb == '0);
    assign div_ovf  = mdu_op_is_div(I_op) & mdu_op_b_signed(I_op) &
                      (I_srca == MOST_NEG) & (I_srcb == '1);
    assign early    = mdu_op_is_div(I_op) & (div_zero | div_ovf);
    // op[1] separates remainder ops from quotient ops.
    assign early_res = I_op[1] ? (div_zero ? I_srca : '0)
                               : (div_zero ? '1 : MOST_NEG);

    assign div_step = (state_q == StDiv);

    exe_mdu_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk     (clk),
        .load    (accept),
        .step    (div_step),
        .dividend(mag_a),
        .divisor (mag_b),
        .quot    (div_quot),
        .rem     (div_rem)
    );

    // Low half of prod_q holds the unretired multiplier bits; the high half accumulates.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (prod_q[i]) begin
                partial = partial + ({{MUL_BITS{1'b0}}, mcand_q} << i);
            end
        end
        mul_sum = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial;
    end

    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        quot_fix = neg_q ? -div_quot : div_quot;
        rem_fix  = sign_a_q ? -div_rem : div_rem;
        case (op_q)
            MDU_OP_MUL:                              fix_result = prod_fix[XLEN-1:0];
            MDU_OP_MULH, MDU_OP_MULHSU, MDU_OP_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            MDU_OP_DIV, MDU_OP_DIVU:                 fix_result = quot_fix;
            default:                                 fix_result = rem_fix;
        endcase
        if (early_q) begin
            fix_result = early_res_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!mdu_op_is_div(I_op)) state_d = StMul;
                    else if (early)           state_d = StDone;
                    else                      state_d = StDiv;
                end
            end
            StMul:   if (cnt_q == MUL_LAST) state_d = StDone;
            StDiv:   if (cnt_q == DIV_LAST) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (I_annul) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
            end else if ((state_q == StMul) || (state_q == StDiv)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if ((state_q == StDone) && !I_annul) begin
                valid_q  <= 1'b1;
                result_q <= fix_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q        <= I_op;
            neg_q       <= sign_a ^ sign_b;
            sign_a_q    <= sign_a;
            early_q     <= early;
            early_res_q <= early_res;
            mcand_q     <= mag_a;
            prod_q      <= {{XLEN{1'b0}}, mag_b};
        end else if (state_q == StMul) begin
            prod_q <= {mul_sum, prod_q[XLEN-1:MUL_BITS]};
        end
    end

    assign O_ready  = (state_q == StIdle);
    assign O_valid  = valid_q;
    assign O_result = result_q;

endmodule
